// File: rtl/rs_pkg.sv
// RS(255,221) shared definitions: GF(2^8) field constants, multiply helper,
// generator polynomial coefficients (computed at elaboration) and FSM states.
// Imported by gf_const_mul and rs_encoder221.
package rs_pkg;

  localparam logic [8:0] GF_POLY = 9'h11D;
  localparam int         RS_N    = 255;
  localparam int         RS_K    = 221;
  localparam int         RS_NPAR = RS_N - RS_K;

  // Coefficients of g(x) below the implicit monic x^34 term, index = degree.
  typedef logic [0:RS_NPAR-1][7:0] gen_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MSG    = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Shift-and-add multiply; each doubling reduces by the primitive polynomial.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[7] ? ({sh[6:0], 1'b0} ^ GF_POLY[7:0]) : {sh[6:0], 1'b0};
    end
    return acc;
  endfunction

  // Expands prod_{i=1..34} (x + alpha^i); in GF(2^m) subtraction is XOR.
  function automatic gen_t rs_gen_calc();
    logic [0:RS_NPAR][7:0] g;
    logic [7:0]            root;
    gen_t                  res;
    g    = '0;
    g[0] = 8'h01;
    root = 8'h01;
    for (int i = 1; i <= RS_NPAR; i++) begin
      root = gf_mul(root, 8'h02);
      for (int j = i; j >= 1; j--) begin
        g[j] = g[j-1] ^ gf_mul(g[j], root);
      end
      g[0] = gf_mul(g[0], root);
    end
    for (int j = 0; j < RS_NPAR; j++) res[j] = g[j];
    return res;
  endfunction

  localparam gen_t RS_GEN = rs_gen_calc();

endpackage

// File: rtl/rs_encoder221_if.sv
// Byte-stream interface of the RS(255,221) encoder.
// Ports: message side (new_data, data_in, data_ready, optional msg_len) and
// codeword side (codeword_out/valid/start_flag/end_flag, parity_addr).
// msg_len exists only when RS_ENC_SHORTENED_EN is defined.
interface rs_encoder221_if #(parameter int width = 6);

  logic             new_data;
  logic [7:0]       data_in;
  logic             data_ready;
  logic [7:0]       codeword_out;
  logic             codeword_valid;
  logic             codeword_start_flag;
  logic             codeword_end_flag;
  logic [width-1:0] parity_addr;

`ifdef RS_ENC_SHORTENED_EN
  logic [7:0]       msg_len;

  modport master (
    output new_data, data_in, msg_len,
    input  data_ready, codeword_out, codeword_valid,
    input  codeword_start_flag, codeword_end_flag, parity_addr
  );

  modport slave (
    input  new_data, data_in, msg_len,
    output data_ready, codeword_out, codeword_valid,
    output codeword_start_flag, codeword_end_flag, parity_addr
  );
`else
  modport master (
    output new_data, data_in,
    input  data_ready, codeword_out, codeword_valid,
    input  codeword_start_flag, codeword_end_flag, parity_addr
  );

  modport slave (
    input  new_data, data_in,
    output data_ready, codeword_out, codeword_valid,
    output codeword_start_flag, codeword_end_flag, parity_addr
  );
`endif

endinterface

// File: rtl/rs_encoder221_gf_const_mul.sv
// GF(2^8) multiply of an 8-bit input by a constant coefficient (pure XOR net).
// Ports: din (operand), dout (din * coef), combinational, no latency.
// coef is fixed per instance, so gf_mul folds down to a constant matrix.
module gf_const_mul
  import rs_pkg::*;
#(
  parameter logic [7:0] coef = 8'h01
) (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = gf_mul(din, coef);

endmodule

// File: rtl/rs_encoder221.sv
// Systematic RS(255,221) encoder: forwards L message bytes then appends 34 parity bytes.
// Ports: clock, reset (async, active-high), bus (rs_encoder221_if.slave).
// Outputs registered, 1-cycle latency; data_ready low for the 34 parity cycles.
// Optional macro RS_ENC_SHORTENED_EN: per-codeword length L from bus.msg_len.
module rs_encoder221
  import rs_pkg::*;
#(
  parameter int width           = 6,
  parameter int number_of_coefs = 34,
  parameter int msg_symbols     = 221
) (
  input  logic             clock,
  input  logic             reset,
  rs_encoder221_if.slave   bus
);

  localparam logic [width-1:0] P_LAST = width'(number_of_coefs - 1);
  localparam logic [7:0]       L_FULL = 8'(msg_symbols);

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       par  [0:number_of_coefs-1];
  logic [7:0]       prod [0:number_of_coefs-1];
  logic [7:0]       fb;
  logic [7:0]       msg_count;
  logic [7:0]       len_q;
  logic [7:0]       len_in;
  logic [width-1:0] pcnt;
  logic             data_ready;
  logic             accept;
  logic             last_msg;

  logic [7:0]       cw_out;
  logic             cw_vld;
  logic             cw_sflag;
  logic             cw_eflag;
  logic [width-1:0] paddr;

`ifdef RS_ENC_SHORTENED_EN
  // Out-of-range lengths fall back to the full code.
  assign len_in = (bus.msg_len == 8'd0 || bus.msg_len > L_FULL) ? L_FULL : bus.msg_len;
`else
  assign len_in = L_FULL;
`endif

  assign data_ready = (state != PARITY);
  assign accept     = bus.new_data & data_ready;
  // In IDLE the length register is not loaded yet, so use the live value.
  assign last_msg   = (state == IDLE) ? (len_in == 8'd1) : ((msg_count + 8'd1) == len_q);

  // Division LFSR feedback: incoming byte plus the highest-degree remainder term.
  assign fb = bus.data_in ^ par[number_of_coefs-1];

  for (genvar j = 0; j < number_of_coefs; j++) begin : g_coef
    gf_const_mul #(.coef(RS_GEN[j])) u_mul (
      .din  (fb),
      .dout (prod[j])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = last_msg ? PARITY : MSG;
      MSG:     if (accept && last_msg) state_nxt = PARITY;
      PARITY:  if (pcnt == P_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      msg_count <= 8'd0;
      len_q     <= L_FULL;
      pcnt      <= '0;
      for (int j = 0; j < number_of_coefs; j++) par[j] <= 8'h00;
      cw_out    <= 8'h00;
      cw_vld    <= 1'b0;
      cw_sflag  <= 1'b0;
      cw_eflag  <= 1'b0;
      paddr     <= '0;
    end else begin
      state    <= state_nxt;
      cw_vld   <= 1'b0;
      cw_sflag <= 1'b0;
      cw_eflag <= 1'b0;
      paddr    <= '0;
      case (state)
        IDLE, MSG: begin
          if (accept) begin
            par[0] <= prod[0];
            for (int j = 1; j < number_of_coefs; j++) par[j] <= par[j-1] ^ prod[j];
            cw_out <= bus.data_in;
            cw_vld <= 1'b1;
            if (state == IDLE) begin
              cw_sflag  <= 1'b1;
              msg_count <= 8'd1;
              len_q     <= len_in;
            end else begin
              msg_count <= msg_count + 8'd1;
            end
          end
        end
        PARITY: begin
          cw_out <= par[number_of_coefs-1];
          cw_vld <= 1'b1;
          paddr  <= pcnt;
          par[0] <= 8'h00;
          for (int j = 1; j < number_of_coefs; j++) par[j] <= par[j-1];
          if (pcnt == P_LAST) begin
            cw_eflag  <= 1'b1;
            pcnt      <= '0;
            msg_count <= 8'd0;
            for (int j = 0; j < number_of_coefs; j++) par[j] <= 8'h00;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.data_ready          = data_ready;
  assign bus.codeword_out        = cw_out;
  assign bus.codeword_valid      = cw_vld;
  assign bus.codeword_start_flag = cw_sflag;
  assign bus.codeword_end_flag   = cw_eflag;
  assign bus.parity_addr         = paddr;

endmodule

// File: tb/tb_rs_encoder221.sv
// Directed self-checking bench for rs_encoder221.
// Independent log/antilog GF model gives generator coefficients and syndromes.
// Monitor captures every valid output byte with flags and cycle stamp.
module tb_rs_encoder221;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         end_cnt = 0;
  int         rdy_low = 0;

  logic [7:0] cap_q [$];
  bit         sf_q  [$];
  bit         ef_q  [$];
  logic [5:0] pa_q  [$];
  int         cyc_q [$];

  logic [7:0] gexp [0:255];
  int         glog [0:255];
  logic [7:0] gen  [0:34];
  logic [7:0] msg  [0:220];
  logic [7:0] rnd  [0:220];
  logic [7:0] ref_cw [0:254];

  rs_encoder221_if #(.width(6)) bus();

  rs_encoder221 #(.width(6), .number_of_coefs(34), .msg_symbols(221)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (!reset && bus.codeword_valid) begin
      cap_q.push_back(bus.codeword_out);
      sf_q.push_back(bus.codeword_start_flag);
      ef_q.push_back(bus.codeword_end_flag);
      pa_q.push_back(bus.parity_addr);
      cyc_q.push_back(cyc);
      if (bus.codeword_end_flag) end_cnt = end_cnt + 1;
    end
    if (!reset && !bus.data_ready) rdy_low = rdy_low + 1;
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  function automatic logic [7:0] syndrome(input int j, input int base, input int n);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < n; i++) s = gmul(s, gexp[j]) ^ cap_q[base+i];
    return s;
  endfunction

  task automatic build_model();
    int x;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = 8'(x);
      glog[x] = i;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11D;
    end
    gexp[255] = gexp[0];
    glog[0]   = 0;
    for (int j = 0; j <= 34; j++) gen[j] = 8'h00;
    gen[0] = 8'h01;
    for (int i = 1; i <= 34; i++) begin
      for (int j = i; j >= 1; j--) gen[j] = gen[j-1] ^ gmul(gen[j], gexp[i]);
      gen[0] = gmul(gen[0], gexp[i]);
    end
  endtask

  // Called and returns in the posedge+1 phase.
  task automatic send(input int len, input bit gaps);
    int guard;
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < len && ok; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.new_data = 1'b0;
          @(posedge clock); #1;
        end
      end
      bus.new_data = 1'b1;
      bus.data_in  = msg[i];
      guard = 0;
      while (!bus.data_ready && guard < 100) begin
        @(posedge clock); #1;
        guard++;
      end
      if (guard >= 100) ok = 1'b0;
      else begin
        @(posedge clock); #1;
      end
    end
    bus.new_data = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_accept got=data_ready stuck low want=byte accepted");
    end
  endtask

  task automatic wait_end(input int target, input string name);
    int n;
    n = 0;
    while (end_cnt < target && n < 400) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (end_cnt < target) begin
      failures++;
      $display("FAIL %s_end_timeout got=%0d want=%0d", name, end_cnt, target);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.new_data = 1'b0;
    bus.data_in  = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (bus.codeword_out !== 8'h00) begin failures++; $display("FAIL reset_out got=%h want=00", bus.codeword_out); end
    checks++; if (bus.codeword_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", bus.codeword_valid); end
    checks++; if (bus.codeword_start_flag !== 1'b0) begin failures++; $display("FAIL reset_start got=%b want=0", bus.codeword_start_flag); end
    checks++; if (bus.codeword_end_flag !== 1'b0) begin failures++; $display("FAIL reset_end got=%b want=0", bus.codeword_end_flag); end
    checks++; if (bus.parity_addr !== 6'd0) begin failures++; $display("FAIL reset_paddr got=%0d want=0", bus.parity_addr); end
    checks++; if (bus.data_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", bus.data_ready); end
    reset = 1'b0;
  endtask

  task automatic test_all_zero();
    int b, e0, n, bad;
    for (int i = 0; i < 221; i++) msg[i] = 8'h00;
    b = cap_q.size(); e0 = end_cnt;
    send(221, 1'b0);
    wait_end(e0 + 1, "zero");
    n = cap_q.size() - b;
    checks++; if (n !== 255) begin failures++; $display("FAIL zero_len got=%0d want=255", n); end
    if (n >= 255) begin
      bad = 0;
      for (int i = 0; i < 255; i++) if (cap_q[b+i] !== 8'h00) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL zero_bytes got=%0d nonzero want=0", bad); end
      checks++; if (sf_q[b] !== 1'b1) begin failures++; $display("FAIL zero_start got=%b want=1", sf_q[b]); end
      checks++; if (ef_q[b+254] !== 1'b1) begin failures++; $display("FAIL zero_end got=%b want=1", ef_q[b+254]); end
      bad = 0;
      for (int i = 1; i < 255; i++) if (sf_q[b+i] !== 1'b0) bad++;
      for (int i = 0; i < 254; i++) if (ef_q[b+i] !== 1'b0) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL zero_flag_pulses got=%0d extra want=0", bad); end
      bad = 0;
      for (int i = 0; i < 221; i++) if (pa_q[b+i] !== 6'd0) bad++;
      for (int k = 0; k < 34; k++) if (pa_q[b+221+k] !== 6'(k)) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL zero_paddr got=%0d wrong want=0", bad); end
      checks++; if (cyc_q[b+254] - cyc_q[b] !== 254) begin failures++; $display("FAIL zero_span got=%0d want=254", cyc_q[b+254] - cyc_q[b]); end
    end
  endtask

  task automatic test_unit();
    int b, e0, n;
    for (int i = 0; i < 221; i++) msg[i] = 8'h00;
    msg[220] = 8'h01;
    b = cap_q.size(); e0 = end_cnt;
    send(221, 1'b0);
    wait_end(e0 + 1, "unit");
    n = cap_q.size() - b;
    checks++; if (n !== 255) begin failures++; $display("FAIL unit_len got=%0d want=255", n); end
    if (n >= 255) begin
      checks++; if (cap_q[b+220] !== 8'h01) begin failures++; $display("FAIL unit_last_msg got=%h want=01", cap_q[b+220]); end
      for (int k = 0; k < 34; k++) begin
        checks++;
        if (cap_q[b+221+k] !== gen[33-k]) begin
          failures++;
          $display("FAIL unit_parity_%0d got=%h want=%h", k, cap_q[b+221+k], gen[33-k]);
        end
      end
    end
  endtask

  task automatic test_random();
    int b, e0, n, bad, r0;
    for (int i = 0; i < 221; i++) begin
      rnd[i] = 8'($urandom_range(0, 255));
      msg[i] = rnd[i];
    end
    b = cap_q.size(); e0 = end_cnt; r0 = rdy_low;
    send(221, 1'b0);
    wait_end(e0 + 1, "random");
    n = cap_q.size() - b;
    checks++; if (n !== 255) begin failures++; $display("FAIL random_len got=%0d want=255", n); end
    checks++; if (rdy_low - r0 !== 34) begin failures++; $display("FAIL random_ready_low got=%0d want=34", rdy_low - r0); end
    if (n >= 255) begin
      bad = 0;
      for (int i = 0; i < 221; i++) if (cap_q[b+i] !== rnd[i]) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL random_passthru got=%0d wrong want=0", bad); end
      for (int j = 1; j <= 34; j++) begin
        checks++;
        if (syndrome(j, b, 255) !== 8'h00) begin
          failures++;
          $display("FAIL random_syndrome_%0d got=%h want=00", j, syndrome(j, b, 255));
        end
      end
      for (int i = 0; i < 255; i++) ref_cw[i] = cap_q[b+i];
    end
  endtask

  task automatic test_gaps();
    int b, e0, n, bad, r0;
    for (int i = 0; i < 221; i++) msg[i] = rnd[i];
    b = cap_q.size(); e0 = end_cnt; r0 = rdy_low;
    send(221, 1'b1);
    wait_end(e0 + 1, "gaps");
    n = cap_q.size() - b;
    checks++; if (n !== 255) begin failures++; $display("FAIL gaps_len got=%0d want=255", n); end
    checks++; if (rdy_low - r0 !== 34) begin failures++; $display("FAIL gaps_ready_low got=%0d want=34", rdy_low - r0); end
    if (n >= 255) begin
      bad = 0;
      for (int i = 0; i < 255; i++) if (cap_q[b+i] !== ref_cw[i]) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL gaps_codeword got=%0d wrong want=0", bad); end
    end
  endtask

  task automatic test_reset_mid();
    int b, e0, n, bad;
    for (int i = 0; i < 221; i++) msg[i] = rnd[i];
    send(100, 1'b0);
    checks++; if (bus.codeword_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b want=1", bus.codeword_valid); end
    reset = 1'b1;
    #1;
    checks++; if (bus.codeword_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b want=0", bus.codeword_valid); end
    checks++; if (bus.codeword_out !== 8'h00) begin failures++; $display("FAIL mid_out got=%h want=00", bus.codeword_out); end
    checks++; if (bus.data_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b want=1", bus.data_ready); end
    @(posedge clock); #1;
    reset = 1'b0;
    b = cap_q.size(); e0 = end_cnt;
    send(221, 1'b0);
    wait_end(e0 + 1, "mid");
    n = cap_q.size() - b;
    checks++; if (n !== 255) begin failures++; $display("FAIL mid_len got=%0d want=255", n); end
    if (n >= 255) begin
      bad = 0;
      for (int i = 0; i < 255; i++) if (cap_q[b+i] !== ref_cw[i]) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL mid_codeword got=%0d wrong want=0", bad); end
    end
  endtask

  task automatic test_back_to_back();
    int b, e0, n, bad;
    for (int i = 0; i < 221; i++) msg[i] = rnd[i];
    b = cap_q.size(); e0 = end_cnt;
    send(221, 1'b0);
    send(221, 1'b0);
    wait_end(e0 + 2, "b2b");
    n = cap_q.size() - b;
    checks++; if (n !== 510) begin failures++; $display("FAIL b2b_len got=%0d want=510", n); end
    if (n >= 510) begin
      bad = 0;
      for (int i = 0; i < 510; i++) if (cap_q[b+i] !== ref_cw[i % 255]) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_codewords got=%0d wrong want=0", bad); end
      checks++; if (sf_q[b+255] !== 1'b1) begin failures++; $display("FAIL b2b_second_start got=%b want=1", sf_q[b+255]); end
      checks++; if (cyc_q[b+255] - cyc_q[b+254] !== 1) begin failures++; $display("FAIL b2b_gap got=%0d want=1", cyc_q[b+255] - cyc_q[b+254]); end
    end
  endtask

`ifdef RS_ENC_SHORTENED_EN
  task automatic test_shortened();
    int b, e0, n, bad;
    bus.msg_len = 8'd1;
    msg[0] = 8'h01;
    b = cap_q.size(); e0 = end_cnt;
    send(1, 1'b0);
    wait_end(e0 + 1, "short1");
    n = cap_q.size() - b;
    checks++; if (n !== 35) begin failures++; $display("FAIL short1_len got=%0d want=35", n); end
    if (n >= 35) begin
      checks++; if (cap_q[b] !== 8'h01) begin failures++; $display("FAIL short1_msg got=%h want=01", cap_q[b]); end
      checks++; if (ef_q[b+34] !== 1'b1) begin failures++; $display("FAIL short1_end got=%b want=1", ef_q[b+34]); end
      for (int k = 0; k < 34; k++) begin
        checks++;
        if (cap_q[b+1+k] !== gen[33-k]) begin
          failures++;
          $display("FAIL short1_parity_%0d got=%h want=%h", k, cap_q[b+1+k], gen[33-k]);
        end
      end
    end
    bus.msg_len = 8'd3;
    for (int i = 0; i < 3; i++) msg[i] = rnd[i];
    b = cap_q.size(); e0 = end_cnt;
    send(3, 1'b0);
    wait_end(e0 + 1, "short3");
    n = cap_q.size() - b;
    checks++; if (n !== 37) begin failures++; $display("FAIL short3_len got=%0d want=37", n); end
    if (n >= 37) begin
      bad = 0;
      for (int j = 1; j <= 34; j++) if (syndrome(j, b, 37) !== 8'h00) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL short3_syndromes got=%0d nonzero want=0", bad); end
    end
    for (int t = 0; t < 2; t++) begin
      bus.msg_len = (t == 0) ? 8'd0 : 8'd250;
      for (int i = 0; i < 221; i++) msg[i] = rnd[i];
      b = cap_q.size(); e0 = end_cnt;
      send(221, 1'b0);
      wait_end(e0 + 1, "clamp");
      n = cap_q.size() - b;
      checks++; if (n !== 255) begin failures++; $display("FAIL clamp_len_%0d got=%0d want=255", t, n); end
      if (n >= 255) begin
        bad = 0;
        for (int i = 0; i < 255; i++) if (cap_q[b+i] !== ref_cw[i]) bad++;
        checks++; if (bad !== 0) begin failures++; $display("FAIL clamp_codeword_%0d got=%0d wrong want=0", t, bad); end
      end
    end
    bus.msg_len = 8'd221;
  endtask
`endif

  initial begin
    bus.new_data = 1'b0;
    bus.data_in  = 8'h00;
`ifdef RS_ENC_SHORTENED_EN
    bus.msg_len  = 8'd221;
`endif
    build_model();
    test_reset();
    test_all_zero();
    test_unit();
    test_random();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
`ifdef RS_ENC_SHORTENED_EN
    test_shortened();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
